// File: rtl/rocketcpu_pkg.sv
// rtl/rocketcpu_pkg.sv - shared constants and state encoding for the RocketCPU Wishbone initiator
package rocketcpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_BUS   = 3'd2,
    ST_GAP   = 3'd3,
    ST_RSP   = 3'd4
  } wb_state_e;

  localparam logic [3:0]  WB_SEL_ALL     = 4'hF;
  localparam logic [31:0] WB_WORD_STRIDE = 32'd4;
  localparam logic [31:0] AUDIO_BASE     = 32'h1000_0000;
  localparam logic [31:0] STATUS_BASE    = 32'h1001_0000;

endpackage

// File: rtl/rocketcpu_wb_initiator.sv
// rtl/rocketcpu_wb_initiator.sv - command/response stream to Wishbone classic single-beat bursts
// Optional ack timeout: ROCKETCPU_WB_TIMEOUT_EN
module rocketcpu_wb_initiator
  import rocketcpu_pkg::*;
#(
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             i_wb_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [31:0]      i_cmd_adr,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_wdat_valid,
  output logic             o_wdat_ready,
  input  logic [31:0]      i_wdat,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_dat,
  output logic             o_rsp_err,
  output logic             o_rsp_last,
  output logic             o_busy,
  output logic [31:0]      o_wb_adr,
  output logic [31:0]      o_wb_dat,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  input  logic [31:0]      i_wb_rdt,
  input  logic             i_wb_ack
);

  wb_state_e        state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_last_q, rsp_last_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cyc_q, cyc_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             wdat_ready_q, wdat_ready_d;
  logic             busy_q, busy_d;
  logic             timeout;

`ifdef ROCKETCPU_WB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  assign timeout = (state_q == ST_BUS) && !i_wb_ack && (wait_q == WAIT_LAST);

  always_comb begin
    wait_d = '0;
    if (state_q == ST_BUS && !i_wb_ack) wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_rst_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    wdat_d     = wdat_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          we_d    = i_cmd_we;
          adr_d   = i_cmd_adr;
          cnt_d   = i_cmd_len;
          state_d = i_cmd_we ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA: begin
        if (i_wdat_valid && wdat_ready_q) begin
          wdat_d  = i_wdat;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack is honoured only here; late acks from a draining responder land in GAP and are dropped.
        if (i_wb_ack) begin
          rsp_dat_d = we_q ? 32'h0 : i_wb_rdt;
          adr_d     = adr_q + WB_WORD_STRIDE;
          state_d   = ST_GAP;
        end else if (timeout) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (rsp_err_q || !we_q || cnt_q == '0) begin
          rsp_last_d = rsp_err_q || (cnt_q == '0);
          state_d    = ST_RSP;
        end else begin
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = ST_WDATA;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          rsp_err_d = 1'b0;
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_BUS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cyc_d        = (state_d == ST_BUS);
    cmd_ready_d  = (state_d == ST_IDLE);
    wdat_ready_d = (state_d == ST_WDATA);
    rsp_valid_d  = (state_d == ST_RSP);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      cnt_q        <= '0;
      wdat_q       <= 32'h0;
      rsp_dat_q    <= 32'h0;
      rsp_last_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cyc_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      wdat_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      wdat_q       <= wdat_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_last_q   <= rsp_last_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      cyc_q        <= cyc_d;
      cmd_ready_q  <= cmd_ready_d;
      wdat_ready_q <= wdat_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_wdat_ready = wdat_ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_dat    = rsp_dat_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_rsp_last   = rsp_last_q;
  assign o_busy       = busy_q;
  assign o_wb_adr     = adr_q;
  assign o_wb_dat     = wdat_q;
  assign o_wb_sel     = WB_SEL_ALL;
  assign o_wb_we      = we_q;
  assign o_wb_cyc     = cyc_q;

endmodule

// File: tb/tb_rocketcpu_wb_initiator.sv
// tb/tb_rocketcpu_wb_initiator.sv - directed self-checking bench for rocketcpu_wb_initiator
module tb_rocketcpu_wb_initiator;
  import rocketcpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [7:0]  cmd_len = 8'h0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [31:0] wdat = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt = 32'h0;
  logic        wb_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int          ack_lat = 1;
  bit          resp_en = 1'b1;
  bit          spur_gap = 1'b0;
  bit          spur_idle = 1'b0;
  int          cyc_age = 0;
  int          cyc_pulses = 0;
  logic        cyc_prev = 1'b0;
  logic [31:0] rd_q[$];
  logic [31:0] ack_adr[$];
  logic [31:0] ack_dat[$];
  logic [3:0]  ack_sel[$];
  logic        ack_we[$];

  always #5 clk = ~clk;

  rocketcpu_wb_initiator dut (
    .i_wb_clk    (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_we    (cmd_we),
    .i_cmd_adr   (cmd_adr),
    .i_cmd_len   (cmd_len),
    .i_wdat_valid(wdat_valid),
    .o_wdat_ready(wdat_ready),
    .i_wdat      (wdat),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_dat   (rsp_dat),
    .o_rsp_err   (rsp_err),
    .o_rsp_last  (rsp_last),
    .o_busy      (busy),
    .o_wb_adr    (wb_adr),
    .o_wb_dat    (wb_dat),
    .o_wb_sel    (wb_sel),
    .o_wb_we     (wb_we),
    .o_wb_cyc    (wb_cyc),
    .i_wb_rdt    (wb_rdt),
    .i_wb_ack    (wb_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus responder: acks after ack_lat cycles of cyc, optionally pulses a stray ack while cyc is low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        wb_ack   = spur_gap && !wb_cyc;
        spur_gap = 1'b0;
        cyc_age  = 0;
      end else if (resp_en && wb_cyc) begin
        cyc_age++;
        if (cyc_age >= ack_lat) begin
          wb_rdt = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0_0000;
          wb_ack = 1'b1;
          ack_adr.push_back(wb_adr);
          ack_dat.push_back(wb_dat);
          ack_sel.push_back(wb_sel);
          ack_we.push_back(wb_we);
        end
      end else if (spur_idle && !wb_cyc) begin
        wb_ack    = 1'b1;
        wb_rdt    = 32'hFFFF_0000;
        spur_idle = 1'b0;
        cyc_age   = 0;
      end else begin
        cyc_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (wb_cyc && !cyc_prev) cyc_pulses++;
    cyc_prev <= wb_cyc;
  end

  task automatic clear_logs();
    rd_q.delete();
    ack_adr.delete();
    ack_dat.delete();
    ack_sel.delete();
    ack_we.delete();
    cyc_pulses = 0;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("cmd_wait", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_wdat(input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    wdat_valid = 1'b1;
    wdat       = d;
    while (!wdat_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("wdat_wait", 0, 1);
    @(posedge clk);
    #1 wdat_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic l, output logic e);
    int t = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("rsp_wait", 0, 1);
    d = rsp_dat;
    l = rsp_last;
    e = rsp_err;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        l;
    logic        e;
    logic [31:0] exp_rd[4];
    int          t;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outs", {busy, rsp_valid, rsp_last, rsp_err, wb_cyc, wb_we, wdat_ready}, 0);
    check("rst_sel", wb_sel, 4'hF);
    check("rst_adr_dat", {wb_adr, wb_dat}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Single write, ack after 2 cycles
    clear_logs();
    ack_lat = 2;
    send_cmd(1'b1, AUDIO_BASE + 32'h8, 8'd0);
    send_wdat(32'hDEAD_BEEF);
    get_rsp(d, l, e);
    check("wr_pulses", cyc_pulses, 1);
    check("wr_acks", ack_adr.size(), 1);
    if (ack_adr.size() == 1) begin
      check("wr_adr", ack_adr[0], 32'h1000_0008);
      check("wr_dat", ack_dat[0], 32'hDEAD_BEEF);
      check("wr_we_sel", {ack_we[0], ack_sel[0]}, 5'h1F);
    end
    check("wr_rsp", {d, l, e}, {32'h0, 1'b1, 1'b0});

    // Read burst of 4
    clear_logs();
    ack_lat = 1;
    exp_rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    foreach (exp_rd[i]) rd_q.push_back(exp_rd[i]);
    send_cmd(1'b0, AUDIO_BASE, 8'd3);
    for (int i = 0; i < 4; i++) begin
      get_rsp(d, l, e);
      check($sformatf("rd_rsp%0d", i), {d, l, e}, {exp_rd[i], (i == 3), 1'b0});
    end
    check("rd_pulses", cyc_pulses, 4);
    check("rd_acks", ack_adr.size(), 4);
    if (ack_adr.size() == 4)
      for (int i = 0; i < 4; i++)
        check($sformatf("rd_adr%0d", i), {ack_we[i], ack_adr[i]}, {1'b0, AUDIO_BASE + 32'(4 * i)});

    // Response back-pressure: held stable, no new cyc
    clear_logs();
    rd_q.push_back(32'h55);
    rd_q.push_back(32'h66);
    send_cmd(1'b0, STATUS_BASE, 8'd1);
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {rsp_valid, wb_cyc, rsp_last, rsp_dat}, {1'b1, 1'b0, 1'b0, 32'h55});
    end
    check("bp_pulses", cyc_pulses, 1);
    get_rsp(d, l, e);
    check("bp_rsp0", {d, l}, {32'h55, 1'b0});
    get_rsp(d, l, e);
    check("bp_rsp1", {d, l}, {32'h66, 1'b1});
    check("bp_adr1", ack_adr.size() == 2 ? ack_adr[1] : 32'hX, STATUS_BASE + 32'h4);

    // Stray acks in IDLE and GAP are ignored
    clear_logs();
    spur_idle = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_idle_state", {busy, cmd_ready, rsp_valid}, 3'b010);
    rd_q.push_back(32'hA1);
    rd_q.push_back(32'hA2);
    spur_gap = 1'b1;
    send_cmd(1'b0, AUDIO_BASE + 32'h10, 8'd1);
    get_rsp(d, l, e);
    check("spur_rsp0", {d, l}, {32'hA1, 1'b0});
    get_rsp(d, l, e);
    check("spur_rsp1", {d, l}, {32'hA2, 1'b1});
    check("spur_acks", {8'(ack_adr.size()), 8'(cyc_pulses)}, {8'd2, 8'd2});
    @(negedge clk);
    check("spur_idle_end", {busy, cmd_ready}, 2'b01);

    // Address wrap at top of space
    clear_logs();
    rd_q.push_back(32'hC0);
    rd_q.push_back(32'hC4);
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
    get_rsp(d, l, e);
    get_rsp(d, l, e);
    check("wrap_last", {d, l, e}, {32'hC4, 1'b1, 1'b0});
    if (ack_adr.size() == 2) check("wrap_adr", {ack_adr[0], ack_adr[1]}, {32'hFFFF_FFFC, 32'h0});
    else check("wrap_acks", ack_adr.size(), 2);

    // Reset while cyc is high mid-burst
    clear_logs();
    ack_lat = 3;
    send_cmd(1'b0, AUDIO_BASE, 8'd3);
    t = 0;
    while (!wb_cyc && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_cyc_seen", wb_cyc, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_cyc", {wb_cyc, rsp_valid, busy}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release", {cmd_ready, busy, rsp_valid}, 3'b100);
    repeat (5) @(negedge clk);
    check("mid_rst_quiet", {wb_cyc, rsp_valid}, 2'b00);

`ifdef ROCKETCPU_WB_TIMEOUT_EN
    // No responder: abort after TIMEOUT_CYCLES
    clear_logs();
    resp_en = 1'b0;
    send_cmd(1'b0, 32'h2000_0000, 8'd2);
    t = 0;
    while (!wb_cyc && t < 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (wb_cyc && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("to_cyc_len", t, 64);
    get_rsp(d, l, e);
    check("to_rsp", {d, l, e}, {32'h0, 1'b1, 1'b1});
    @(negedge clk);
    check("to_idle", {cmd_ready, busy, wb_cyc}, 3'b100);
    resp_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
